riscv_v_dispatch: RTL and testbench



---
 rtl/riscv_v_dispatch.sv | 133 +++++++++++++
 tb/tb_riscv_v_dispatch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/riscv_v_dispatch.sv
// Vector-instruction issue unit: in-order instruction FIFO feeding vector decode,
// plus a pending-writeback queue that routes v2i results back to the scalar RF.
module riscv_v_dispatch #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PEND_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_pipe,
  input  logic                          core_stall,
  input  logic                          riscv_v_stall,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_instr,
  input  logic [XLEN-1:0]               req_rs1_data,
  input  logic                          req_wb,
  input  logic [4:0]                    req_rd,
  output logic [31:0]                   instruction_id,
  output logic [XLEN-1:0]               int_rf_rd_data_id,
  input  logic                          int_rf_wr_en_wb,
  input  logic [XLEN-1:0]               int_rf_wr_data_wb,
  output logic                          rf_wr_en,
  output logic [4:0]                    rf_wr_addr,
  output logic [XLEN-1:0]               rf_wr_data,
  output logic [31:0]                   rd_busy,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [$clog2(PEND_DEPTH):0]   pend_count,
  output logic                          wb_orphan
);

  localparam int unsigned FA = $clog2(DEPTH);
  localparam int unsigned FC = FA + 1;
  localparam int unsigned PA = $clog2(PEND_DEPTH);
  localparam int unsigned PC = PA + 1;
  localparam logic [31:0] VNOP = 32'h0000_0013;

  logic [31:0]     f_instr_q [DEPTH];
  logic [XLEN-1:0] f_rs1_q   [DEPTH];
  logic            f_wb_q    [DEPTH];
  logic [4:0]      f_rd_q    [DEPTH];
  logic [FA-1:0]   f_wr_ptr_q, f_rd_ptr_q;
  logic [FC-1:0]   f_cnt_q, f_cnt_d;

  logic [4:0]      p_rd_q [PEND_DEPTH];
  logic [PA-1:0]   p_wr_ptr_q, p_rd_ptr_q;
  logic [PC-1:0]   p_cnt_q, p_cnt_d;

  logic [31:0]     iss_instr_q;
  logic [XLEN-1:0] iss_rs1_q;

  logic adv, push, head_ok, pop, pend_push, wb_pop;
  logic head_wb;
  logic [4:0] head_rd;

  assign adv       = !core_stall && !riscv_v_stall;
  assign req_ready = f_cnt_q < FC'(DEPTH);
  assign push      = req_valid && req_ready;
  assign head_wb   = f_wb_q[f_rd_ptr_q];
  assign head_rd   = f_rd_q[f_rd_ptr_q];

  // A v2i head waits for a free pending slot and for its rd to be idle (WAW).
  assign head_ok   = (f_cnt_q != '0) &&
                     (!head_wb || ((p_cnt_q < PC'(PEND_DEPTH)) && !rd_busy[head_rd]));
  assign pop       = adv && head_ok;
  assign pend_push = pop && head_wb;
  assign wb_pop    = int_rf_wr_en_wb && (p_cnt_q != '0) && !clear_pipe && !rst;

  assign rf_wr_en   = wb_pop;
  assign rf_wr_addr = p_rd_q[p_rd_ptr_q];
  assign rf_wr_data = int_rf_wr_data_wb;
  assign wb_orphan  = int_rf_wr_en_wb && (p_cnt_q == '0) && !clear_pipe && !rst;

  assign instruction_id    = iss_instr_q;
  assign int_rf_rd_data_id = iss_rs1_q;
  assign fifo_count        = f_cnt_q;
  assign pend_count        = p_cnt_q;

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
      if (PC'(i) < p_cnt_q) rd_busy[p_rd_q[p_rd_ptr_q + PA'(i)]] = 1'b1;
    end
  end

  always_comb begin
    f_cnt_d = f_cnt_q;
    if (push && !pop) f_cnt_d = f_cnt_q + FC'(1);
    else if (!push && pop) f_cnt_d = f_cnt_q - FC'(1);
    p_cnt_d = p_cnt_q;
    if (pend_push && !wb_pop) p_cnt_d = p_cnt_q + PC'(1);
    else if (!pend_push && wb_pop) p_cnt_d = p_cnt_q - PC'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_pipe) begin
      f_wr_ptr_q  <= '0;
      f_rd_ptr_q  <= '0;
      f_cnt_q     <= '0;
      p_wr_ptr_q  <= '0;
      p_rd_ptr_q  <= '0;
      p_cnt_q     <= '0;
      iss_instr_q <= VNOP;
      iss_rs1_q   <= '0;
    end else begin
      if (push) begin
        f_instr_q[f_wr_ptr_q] <= req_instr;
        f_rs1_q[f_wr_ptr_q]   <= req_rs1_data;
        f_wb_q[f_wr_ptr_q]    <= req_wb && (req_rd != 5'd0);
        f_rd_q[f_wr_ptr_q]    <= req_rd;
        f_wr_ptr_q            <= f_wr_ptr_q + FA'(1);
      end
      if (pop) f_rd_ptr_q <= f_rd_ptr_q + FA'(1);
      f_cnt_q <= f_cnt_d;

      if (pend_push) begin
        p_rd_q[p_wr_ptr_q] <= head_rd;
        p_wr_ptr_q         <= p_wr_ptr_q + PA'(1);
      end
      if (wb_pop) p_rd_ptr_q <= p_rd_ptr_q + PA'(1);
      p_cnt_q <= p_cnt_d;

      if (pop) begin
        iss_instr_q <= f_instr_q[f_rd_ptr_q];
        iss_rs1_q   <= f_rs1_q[f_rd_ptr_q];
      end else if (adv) begin
        iss_instr_q <= VNOP;
        iss_rs1_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_dispatch.sv
// Randomized bench for riscv_v_dispatch, checked every cycle against a queue-based model.
module tb_riscv_v_dispatch;

  localparam int DEPTH = 4;
  localparam int PEND  = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] VNOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst, clear_pipe, core_stall, riscv_v_stall;
  logic            req_valid, req_ready, req_wb;
  logic [31:0]     req_instr;
  logic [XLEN-1:0] req_rs1_data;
  logic [4:0]      req_rd;
  logic [31:0]     instruction_id;
  logic [XLEN-1:0] int_rf_rd_data_id;
  logic            int_rf_wr_en_wb;
  logic [XLEN-1:0] int_rf_wr_data_wb;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [31:0]     rd_busy;
  logic [2:0]      fifo_count, pend_count;
  logic            wb_orphan;

  always #5 clk = ~clk;

  riscv_v_dispatch #(.DEPTH(DEPTH), .PEND_DEPTH(PEND), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .clear_pipe(clear_pipe), .core_stall(core_stall),
    .riscv_v_stall(riscv_v_stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_rs1_data(req_rs1_data), .req_wb(req_wb),
    .req_rd(req_rd), .instruction_id(instruction_id),
    .int_rf_rd_data_id(int_rf_rd_data_id), .int_rf_wr_en_wb(int_rf_wr_en_wb),
    .int_rf_wr_data_wb(int_rf_wr_data_wb), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rd_busy(rd_busy),
    .fifo_count(fifo_count), .pend_count(pend_count), .wb_orphan(wb_orphan)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    bit              wb;
    logic [4:0]      rd;
  } ent_t;

  ent_t            mq[$];
  logic [4:0]      mp[$];
  logic [31:0]     m_instr;
  logic [XLEN-1:0] m_rs1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (mp[i]) b[mp[i]] = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    mq.delete();
    mp.delete();
    m_instr = VNOP;
    m_rs1   = '0;
  endtask

  // Applies the edge's effect to the model, using inputs still held from the negedge.
  task automatic model_edge();
    bit adv, push, can, wpop;
    logic [31:0] b;
    ent_t e, n;
    if (rst || clear_pipe) begin
      model_clear();
      return;
    end
    adv  = !core_stall && !riscv_v_stall;
    push = req_valid && (mq.size() < DEPTH);
    b    = model_busy();
    can  = (mq.size() > 0) && (!mq[0].wb || ((mp.size() < PEND) && !b[mq[0].rd]));
    wpop = int_rf_wr_en_wb && (mp.size() > 0);
    if (wpop) void'(mp.pop_front());
    if (adv) begin
      if (can) begin
        e = mq.pop_front();
        m_instr = e.instr;
        m_rs1   = e.rs1;
        if (e.wb) mp.push_back(e.rd);
      end else begin
        m_instr = VNOP;
        m_rs1   = '0;
      end
    end
    if (push) begin
      n.instr = req_instr;
      n.rs1   = req_rs1_data;
      n.wb    = req_wb && (req_rd != 5'd0);
      n.rd    = req_rd;
      mq.push_back(n);
    end
  endtask

  task automatic check_outputs();
    bit exp_wen, exp_orph;
    chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
    chk("instr_id", 64'(instruction_id), 64'(m_instr));
    chk("rs1_id", 64'(int_rf_rd_data_id), 64'(m_rs1));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("pend_count", 64'(pend_count), 64'(mp.size()));
    chk("rd_busy", 64'(rd_busy), 64'(model_busy()));
    exp_wen  = !rst && !clear_pipe && int_rf_wr_en_wb && (mp.size() > 0);
    exp_orph = !rst && !clear_pipe && int_rf_wr_en_wb && (mp.size() == 0);
    chk("rf_wr_en", 64'(rf_wr_en), 64'(exp_wen));
    chk("wb_orphan", 64'(wb_orphan), 64'(exp_orph));
    if (exp_wen) begin
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(mp[0]));
      chk("rf_wr_data", 64'(rf_wr_data), 64'(int_rf_wr_data_wb));
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  initial begin
    int phase;
    rst = 1'b1; clear_pipe = 1'b0; core_stall = 1'b0; riscv_v_stall = 1'b0;
    req_valid = 1'b0; req_instr = '0; req_rs1_data = '0; req_wb = 1'b0; req_rd = '0;
    int_rf_wr_en_wb = 1'b0; int_rf_wr_data_wb = '0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_instr", 64'(instruction_id), 64'(VNOP));
    chk("reset_rs1", 64'(int_rf_rd_data_id), 64'd0);
    chk("reset_fcnt", 64'(fifo_count), 64'd0);
    chk("reset_pcnt", 64'(pend_count), 64'd0);
    chk("reset_busy", 64'(rd_busy), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd1);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      phase = (cyc / 400) % 4;
      rst           = pct(1) && (cyc % 3 == 0);
      clear_pipe    = pct(phase == 3 ? 5 : 1);
      core_stall    = pct(phase == 3 ? 30 : 8);
      riscv_v_stall = pct(phase == 1 ? 75 : 10);
      req_valid     = pct(70);
      req_instr     = $urandom();
      req_rs1_data  = $urandom();
      req_wb        = pct(50);
      req_rd        = pct(80) ? 5'($urandom_range(7, 0)) : 5'($urandom_range(31, 0));
      int_rf_wr_en_wb   = pct(phase == 2 ? 5 : 35);
      int_rf_wr_data_wb = $urandom();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
